// File: rtl/fir_stim_pkg.sv
// Shared definitions for the FIR stimulus generator: sequencer states, mode
// encodings and the fixed 4-entry waveform table.
package fir_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_IMP,
    ST_IMP_LO,
    ST_WAVE,
    ST_WAVE_LO,
    ST_DONE
  } state_e;

  localparam logic [1:0] MODE_STEP = 2'd0;
  localparam logic [1:0] MODE_IMP  = 2'd1;
  localparam logic [1:0] MODE_WAVE = 2'd2;
  localparam logic [1:0] MODE_ALL  = 2'd3;

  localparam int WAVE_LEN = 4;
  // Entry 0 sits in the low byte: 50, 100, 50, 0.
  localparam logic [3:0][7:0] WAVE_TABLE = {8'd0, 8'd50, 8'd100, 8'd50};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fir_wave_rom.sv
// Combinational lookup of the fixed waveform table; kept separate so that
// checkers can reuse the same sample values.
module fir_wave_rom
  import fir_stim_pkg::*;
(
  input  logic [1:0] idx_i,
  output logic [7:0] sample_o
);

  assign sample_o = WAVE_TABLE[idx_i];

endmodule

// File: rtl/fir_stimulus_gen.sv
// Canned sample source for the FIR filter input: step, impulse, periodic
// waveform or all three back-to-back, with pause and start/done handshake.
module fir_stimulus_gen
  import fir_stim_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int STEP_AMP     = 100,
  parameter int STEP_LEN     = 4,
  parameter int GAP_LEN      = 4,
  parameter int IMP_AMP      = 255,
  parameter int IMP_GAP      = 5,
  parameter int WAVE_PERIODS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              hold,
  output logic [DATA_W-1:0] x_out,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

  localparam int MAX_LEN = max_int(max_int(STEP_LEN, GAP_LEN),
                                   max_int(IMP_GAP, WAVE_LEN * WAVE_PERIODS));
  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] IGAP_LAST = CNT_W'(IMP_GAP - 1);
  localparam logic [CNT_W-1:0] WAVE_LAST = CNT_W'(WAVE_LEN * WAVE_PERIODS - 1);

  localparam logic [DATA_W-1:0] STEP_VAL = DATA_W'(STEP_AMP);
  localparam logic [DATA_W-1:0] IMP_VAL  = DATA_W'(IMP_AMP);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  x_out_q, x_out_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   seg_last;
  state_e             seg_next;
  logic               emit;
  logic [7:0]         rom_sample;
  logic [DATA_W-1:0]  seg_sample;

  // Table index follows the counter, so repeated periods wrap 3 -> 0 for free.
  fir_wave_rom u_wave_rom (
    .idx_i    (cnt_d[1:0]),
    .sample_o (rom_sample)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_STEP;
      cnt_q     <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    seg_last = '0;
    seg_next = ST_DONE;
    case (state_q)
      ST_STEP_HI: begin
        seg_last = STEP_LAST;
        seg_next = ST_STEP_LO;
      end
      ST_STEP_LO: begin
        seg_last = GAP_LAST;
        if (mode_q == MODE_ALL) seg_next = ST_IMP;
      end
      ST_IMP: begin
        seg_last = '0;
        seg_next = ST_IMP_LO;
      end
      ST_IMP_LO: begin
        seg_last = IGAP_LAST;
        if (mode_q == MODE_ALL) seg_next = ST_WAVE;
      end
      ST_WAVE: begin
        seg_last = WAVE_LAST;
        seg_next = ST_WAVE_LO;
      end
      ST_WAVE_LO: seg_last = GAP_LAST;
      default: ;
    endcase
  end

  // The registered state always names the sample currently on x_out; each
  // non-held edge moves to the next position and registers its value.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    x_out_d   = x_out_q;
    x_valid_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          cnt_d  = '0;
          emit   = 1'b1;
          case (mode)
            MODE_IMP:  state_d = ST_IMP;
            MODE_WAVE: state_d = ST_WAVE;
            MODE_STEP, MODE_ALL: state_d = ST_STEP_HI;
            default:   state_d = ST_STEP_HI;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (!hold) begin
          emit = 1'b1;
          if (cnt_q == seg_last) begin
            cnt_d   = '0;
            state_d = seg_next;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase

    case (state_d)
      ST_STEP_HI: seg_sample = STEP_VAL;
      ST_IMP:     seg_sample = IMP_VAL;
      ST_WAVE:    seg_sample = DATA_W'(rom_sample);
      default:    seg_sample = '0;
    endcase

    if (state_d == ST_IDLE) begin
      x_out_d = '0;
      busy_d  = 1'b0;
    end else if (emit) begin
      busy_d = 1'b1;
      if (state_d == ST_DONE) begin
        done_d  = 1'b1;
        x_out_d = '0;
      end else begin
        x_valid_d = 1'b1;
        x_out_d   = seg_sample;
      end
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fir_stimulus_gen.sv
// Scoreboard bench for fir_stimulus_gen: a sequence model queues the expected
// samples, a negedge monitor pops them as the DUTs present output.
module tb_fir_stimulus_gen;

  typedef struct packed {
    logic       is_done;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0, hold = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] x_out0, x_out1;
  logic       x_valid0, x_valid1, busy0, busy1, done0, done1;

  int   checks = 0;
  int   passed = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   seq[$];
  logic prev_done[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  fir_stimulus_gen dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode), .hold(hold),
    .x_out(x_out0), .x_valid(x_valid0), .busy(busy0), .done(done0)
  );

  fir_stimulus_gen #(.WAVE_PERIODS(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .hold(hold),
    .x_out(x_out1), .x_valid(x_valid1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int o_x(input int s);   return s ? int'(x_out1) : int'(x_out0); endfunction
  function automatic int o_v(input int s);   return s ? int'(x_valid1) : int'(x_valid0); endfunction
  function automatic int o_b(input int s);   return s ? int'(busy1) : int'(busy0); endfunction
  function automatic int o_d(input int s);   return s ? int'(done1) : int'(done0); endfunction

  // Reference: the sample list a mode produces, straight from the segment rules.
  task automatic build_seq(input logic [1:0] m, input int wp);
    seq.delete();
    if (m == 2'd0 || m == 2'd3) begin
      repeat (4) seq.push_back(100);
      repeat (4) seq.push_back(0);
    end
    if (m == 2'd1 || m == 2'd3) begin
      seq.push_back(255);
      repeat (5) seq.push_back(0);
    end
    if (m == 2'd2 || m == 2'd3) begin
      for (int p = 0; p < wp; p++) begin
        seq.push_back(50); seq.push_back(100); seq.push_back(50); seq.push_back(0);
      end
      repeat (4) seq.push_back(0);
    end
  endtask

  task automatic push_expected(input int s);
    exp_t e;
    foreach (seq[i]) begin
      e.is_done = 1'b0;
      e.val     = seq[i][7:0];
      if (s != 0) q1.push_back(e); else q0.push_back(e);
    end
    e.is_done = 1'b1;
    e.val     = 8'd0;
    if (s != 0) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic mon(input int s, input logic [7:0] xo, input logic xv,
                     input logic dn, input logic bs);
    exp_t e;
    if (xv || dn) begin
      if ((s != 0 ? q1.size() : q0.size()) == 0) begin
        checks++;
        $display("FAIL scb_unexpected dut%0d: x_out=%0d done=%0d, expected no output", s, xo, dn);
      end else begin
        e = (s != 0) ? q1.pop_front() : q0.pop_front();
        chk($sformatf("scb_kind dut%0d", s), int'(dn), int'(e.is_done));
        if (!e.is_done) chk($sformatf("scb_sample dut%0d", s), int'(xo), int'(e.val));
      end
    end
    if (dn) chk($sformatf("done_width dut%0d", s), int'(prev_done[s]), 0);
    if (!bs) chk($sformatf("idle_quiet dut%0d", s), int'({xv, xo}), 0);
    prev_done[s] = dn;
  endtask

  always @(negedge clk) begin
    mon(0, x_out0, x_valid0, done0, busy0);
    mon(1, x_out1, x_valid1, done1, busy1);
  end

  task automatic set_start(input int s, input logic v);
    if (s != 0) start1 = v; else start0 = v;
  endtask

  // One sequence: hs/hl force a hold window (edge count after start), hold_pct
  // adds random holds, stray fires ignored starts while busy, ds raises start
  // in the DONE cycle.
  task automatic run_seq(input int s, input logic [1:0] m, input int hold_pct,
                         input int hs, input int hl, input bit stray, input bit ds);
    int  n, consumed, cyc;
    bit  h;
    build_seq(m, (s != 0) ? 2 : 1);
    n = seq.size();
    push_expected(s);
    @(negedge clk);
    mode = m;
    hold = (hold_pct > 0) ? ($urandom_range(99) < hold_pct) : 1'b0;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    chk("start_busy", o_b(s), 1);
    chk("start_latency", o_v(s), 1);
    consumed = 1;
    cyc = 0;
    while (consumed <= n) begin
      @(negedge clk);
      set_start(s, 1'b0);
      h = (cyc >= hs && cyc < hs + hl) ||
          (hold_pct > 0 && $urandom_range(99) < hold_pct);
      hold = h;
      if (stray && consumed < n && $urandom_range(3) == 0) begin
        set_start(s, 1'b1);
        mode = 2'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (h) begin
        chk("hold_valid", o_v(s), 0);
        chk("hold_xout", o_x(s), seq[consumed-1]);
      end else begin
        consumed++;
      end
    end
    chk("done_at_edge", o_d(s), 1);
    chk("done_busy", o_b(s), 1);
    chk("done_xout", o_x(s), 0);
    @(negedge clk);
    hold = 1'($urandom);
    if (ds) set_start(s, 1'b1);
    @(posedge clk); #1;
    chk("busy_fall", o_b(s), 0);
    chk("done_clear", o_d(s), 0);
    @(negedge clk);
    set_start(s, 1'b0);
    hold = 1'b0;
    @(posedge clk); #1;
    chk("stay_idle", o_b(s), 0);
    chk("queue_drained", (s != 0) ? q1.size() : q0.size(), 0);
    repeat ($urandom_range(2)) @(posedge clk);
  endtask

  initial begin
    #12;
    chk("rst_xout", int'(x_out0), 0);
    chk("rst_valid", int'(x_valid0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    #8 rst = 1'b1;

    run_seq(0, 2'd0, 0, -1, 0, 1'b0, 1'b0);
    run_seq(0, 2'd1, 0, -1, 0, 1'b0, 1'b0);
    run_seq(1, 2'd2, 0, -1, 0, 1'b0, 1'b0);
    run_seq(0, 2'd3, 0, -1, 0, 1'b0, 1'b0);
    run_seq(0, 2'd3, 0, 1, 3, 1'b0, 1'b0);
    run_seq(0, 2'd0, 0, -1, 0, 1'b1, 1'b1);

    // Reset in the impulse gap, after an ignored second start.
    build_seq(2'd1, 1);
    push_expected(0);
    @(negedge clk); mode = 2'd1; hold = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    chk("rst_seq_first", int'(x_out0), 255);
    @(negedge clk); start0 = 1'b0;
    @(posedge clk);
    @(negedge clk); start0 = 1'b1; mode = 2'd2;
    @(posedge clk); #1;
    chk("busy_start_ignored", int'({busy0, x_out0}), 256);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy0), 0);
    chk("async_rst_valid", int'(x_valid0), 0);
    chk("async_rst_xout", int'(x_out0), 0);
    q0.delete();
    start0 = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", int'(done0), 0);
    end

    for (int i = 0; i < 10; i++)
      run_seq(0, 2'($urandom), 20, -1, 0, 1'b1, 1'($urandom));
    for (int i = 0; i < 4; i++)
      run_seq(1, 2'($urandom), 20, -1, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fir_stimulus_gen.md
Name: fir_stimulus_gen

Overview:
Hardware sample source that drives the FIR filter's 8-bit sample input with canned test sequences: step, impulse, short periodic waveform, or all three back-to-back.
Sits upstream of fir_filter; its x_out connects directly to the filter's x_in.
Enables on-chip self-test and FPGA bring-up without an external stimulus source.
Sequencing is an FSM with segment counters, a pause control and start/done handshaking.

Parameters:
DATA_W, 8, sample width; must equal the filter input width.
STEP_AMP, 100, step segment amplitude.
STEP_LEN, 4, cycles at STEP_AMP; must be >= 1.
GAP_LEN, 4, zero cycles after the step segment and after the waveform segment; must be >= 1.
IMP_AMP, 255, impulse amplitude.
IMP_GAP, 5, zero cycles after the impulse; must be >= 1.
WAVE_PERIODS, 1, repetitions of the 4-entry waveform; must be >= 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request to begin a sequence; sampled only in IDLE.
mode  in  2  0=step, 1=impulse, 2=waveform, 3=full sequence; latched on an accepted start.
hold  in  1  pause; freezes state and counters.
x_out  out  DATA_W  sample to filter x_in; registered.
x_valid  out  1  x_out is a new sample this cycle.
busy  out  1  a sequence is in progress; high from the accepted start through the DONE cycle.
done  out  1  single-cycle pulse at sequence end.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters 0, x_out=0, x_valid=0, busy=0, done=0.
- FSM states: IDLE, STEP_HI, STEP_LO, IMP, IMP_LO, WAVE, WAVE_LO, DONE.
- IDLE:
  - start=1 on an edge -> mode latched, busy=1, next state = first segment of the mode.
  - First segment per mode: 0/3 -> STEP_HI, 1 -> IMP, 2 -> WAVE.
  - The first sample is visible on x_out immediately after that edge (1-cycle start-to-sample latency).
- Segments; each emits one sample per non-held cycle with x_valid=1:
  - STEP_HI: STEP_LEN samples of STEP_AMP, then STEP_LO.
  - STEP_LO: GAP_LEN zeros, then IMP if mode=3, else DONE.
  - IMP: 1 sample of IMP_AMP, then IMP_LO.
  - IMP_LO: IMP_GAP zeros, then WAVE if mode=3, else DONE.
  - WAVE: table 50,100,50,0 repeated WAVE_PERIODS times, table index wrapping 3->0, then WAVE_LO.
  - WAVE_LO: GAP_LEN zeros, then DONE.
- Waveform table values are fixed 8-bit constants, zero-extended if DATA_W > 8.
- Parameter amplitudes are truncated to DATA_W.
- Segment counter: counts 0..LEN-1; the segment advances when count==LEN-1 on a non-held cycle. Width is clog2 of the largest length parameter, plus 1.
- DONE: lasts exactly one cycle; done=1, x_out=0, x_valid=0, busy=1. Then IDLE with busy=0.
- IDLE output: x_out=0, x_valid=0.
- Full sequence (mode 3, defaults): 22 valid samples. Start accepted at edge k -> done high in the cycle after edge k+22.
- hold=1 in an active segment:
  - state and counters frozen;
  - x_out keeps its last value;
  - x_valid=0;
  - the sample is not consumed; on release, the next edge resumes at the same position.
- hold in IDLE or DONE: no effect.
- start while busy: ignored. mode changes while busy: ignored.
- start=1 in the same cycle that DONE occurs: ignored. A start held high is accepted on the following IDLE cycle.
- Reset asserted mid-sequence: immediate return to IDLE outputs; no done pulse.
- mode is a 2-bit field; there are no illegal mode values.

Decomposition:
- Package fir_stim_pkg holds:
  - state enum;
  - mode constants MODE_STEP, MODE_IMP, MODE_WAVE, MODE_ALL;
  - waveform table constant (4 x 8 bit) and WAVE_LEN=4.
- One sub-module: fir_wave_rom, a 2-bit index -> 8-bit sample, combinational, shared with future checkers.
- Counters and FSM remain in fir_stimulus_gen.

Test Plan:
1. Reset held low 20ns, then released; mode=0 start pulse -> x_out = 100,100,100,100,0,0,0,0 with x_valid=1 each cycle; done pulse the next cycle; busy falls one cycle later.
2. mode=1 -> x_out = 255 then 0 x5; done after 6 valid samples; x_valid never high while idle.
3. mode=2 with WAVE_PERIODS=2 -> x_out = 50,100,50,0,50,100,50,0 then 0 x4; done after 12 valid samples.
4. mode=3 -> exactly 22 valid samples in the order step, impulse, waveform; done pulse width exactly one cycle.
5. mode=3 with hold=1 for 3 cycles at the 2nd step sample -> x_out stays 100 and x_valid=0 for those 3 cycles; the sequence resumes, still totals 22 valid samples, and done is delayed by 3 cycles.
6. rst pulled low mid-impulse gap -> x_out=0, busy=0 asynchronously with no done pulse; a second start while busy is ignored and the sequence count is unchanged.
